adc_init_seq: RTL and testbench

//  Multi-ADC power-up sequencer: one reset pulse to all ADC chips, then a per-chip

---
 rtl/adc_init_pkg.sv | 29 ++
 rtl/adc_seq_timer.sv | 31 +++
 rtl/adc_init_seq.sv | 212 +++++++++++++++++++++
 tb/tb_adc_init_seq.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_init_pkg.sv
// Shared types and helpers for the multi-ADC power-up sequencer.
// State encodings are fixed 4-bit values so unused codes can be recovered to IDLE.
package adc_init_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PRE_RST  = 4'd1,
        ST_ADC_RSTP = 4'd2,
        ST_POST_RST = 4'd3,
        ST_INIT     = 4'd4,
        ST_RETRY    = 4'd5,
        ST_NEXT     = 4'd6,
        ST_SETTLE   = 4'd7,
        ST_RUN      = 4'd8
    } seq_state_e;

    localparam int unsigned RETRY_W = 3;

    // Ceiling log2 with a floor of one bit, so a single-chip build still has an index
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = 32'd1;
        while ((32'd1 << w) < n) begin
            w = w + 32'd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/adc_seq_timer.sv
// Per-state cycle counter for the ADC sequencer: cleared on every state change,
// counts while enabled, flags when the count equals the supplied terminal value.
module adc_seq_timer #(
    parameter int CW = 12
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          clear,
    input  logic          enable,
    input  logic [CW-1:0] term,
    output logic          at_term
);

    logic [CW-1:0] count_r;

    // Cycle counter with clear taking priority over enable
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (enable) begin
            count_r <= count_r + CW'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign at_term = (count_r == term);

endmodule

// File: rtl/adc_init_seq.sv
// Multi-ADC power-up sequencer: shared reset pulse, per-chip init handshake with
// timeout/retry, settle delay, then RUN. Outputs are registered from the next state.
module adc_init_seq
    import adc_init_pkg::*;
#(
    parameter int N_ADC     = 6,
    parameter int CW        = 12,
    parameter int RST_DLY   = 5,
    parameter int RST_LEN   = 7,
    parameter int INIT_DLY  = 5,
    parameter int TIMEOUT   = 4000,
    parameter int MAX_RETRY = 2,
    parameter int SETTLE    = 1000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             REINIT,
    input  logic [N_ADC-1:0] INIT_DONE,
    output logic             ADC_RST,
    output logic [N_ADC-1:0] ADC_INIT,
    output logic             BUSY,
    output logic             RUN,
    output logic             ALL_OK,
    output logic [N_ADC-1:0] ERR
);

    localparam int unsigned IDX_W = idx_width(N_ADC);
    localparam longint MAX_T_A = (longint'(SETTLE) > longint'(TIMEOUT)) ? longint'(SETTLE) : longint'(TIMEOUT);
    localparam longint MAX_T_B = (longint'(RST_DLY) > longint'(RST_LEN)) ? longint'(RST_DLY) : longint'(RST_LEN);
    localparam longint MAX_T_C = (MAX_T_B > longint'(INIT_DLY)) ? MAX_T_B : longint'(INIT_DLY);
    localparam longint MAX_T   = (MAX_T_A > MAX_T_C) ? MAX_T_A : MAX_T_C;

    if ((CW < 1) || (CW > 62) || ((64'd1 << CW) <= MAX_T)) begin : g_cw_too_narrow
        $error("adc_init_seq: CW cannot hold the longest state duration");
    end
    if ((N_ADC < 1) || (N_ADC > 16) || (MAX_RETRY < 0) || (MAX_RETRY > 7)) begin : g_bad_range
        $error("adc_init_seq: N_ADC or MAX_RETRY out of range");
    end
    if ((RST_DLY < 1) || (RST_LEN < 1) || (INIT_DLY < 1) || (TIMEOUT < 1) || (SETTLE < 1)) begin : g_bad_delay
        $error("adc_init_seq: every delay must be at least one cycle");
    end

    localparam logic [CW-1:0]      T_PRE      = CW'(RST_DLY - 1);
    localparam logic [CW-1:0]      T_RSTP     = CW'(RST_LEN - 1);
    localparam logic [CW-1:0]      T_POST     = CW'(INIT_DLY - 1);
    localparam logic [CW-1:0]      T_INIT     = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]      T_SETTLE   = CW'(SETTLE - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_ADC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

    seq_state_e         state_r;
    seq_state_e         state_s;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   idx_s;
    logic [RETRY_W-1:0] retry_r;
    logic [RETRY_W-1:0] retry_s;
    logic [N_ADC-1:0]   err_r;
    logic [N_ADC-1:0]   err_s;
    logic [N_ADC-1:0]   init_vec_s;
    logic [N_ADC-1:0]   adc_init_r;
    logic [CW-1:0]      term_s;
    logic               at_term_s;
    logic               done_s;
    logic               timer_clr_s;
    logic               timer_en_s;
    logic               adc_rst_r;
    logic               busy_r;
    logic               run_r;
    logic               all_ok_r;

    // Terminal count for the state currently being timed
    always_comb begin
        term_s = {CW{1'b0}};
        case (state_r)
            ST_PRE_RST:  term_s = T_PRE;
            ST_ADC_RSTP: term_s = T_RSTP;
            ST_POST_RST: term_s = T_POST;
            ST_INIT:     term_s = T_INIT;
            ST_SETTLE:   term_s = T_SETTLE;
            default:     term_s = {CW{1'b0}};
        endcase
    end

    assign timer_clr_s = (state_s != state_r);
    assign timer_en_s  = (state_r != ST_RUN);

    adc_seq_timer #(
        .CW (CW)
    ) u_timer (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .clear   (timer_clr_s),
        .enable  (timer_en_s),
        .term    (term_s),
        .at_term (at_term_s)
    );

    // Next-state, chip index, retry count and sticky error bookkeeping
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        retry_s = retry_r;
        err_s   = err_r;
        done_s  = INIT_DONE[idx_r];
        case (state_r)
            ST_IDLE: begin
                state_s = ST_PRE_RST;
            end
            ST_PRE_RST: begin
                if (at_term_s) state_s = ST_ADC_RSTP;
                else           state_s = ST_PRE_RST;
            end
            ST_ADC_RSTP: begin
                if (at_term_s) state_s = ST_POST_RST;
                else           state_s = ST_ADC_RSTP;
            end
            ST_POST_RST: begin
                if (at_term_s) begin
                    state_s = ST_INIT;
                    idx_s   = {IDX_W{1'b0}};
                    retry_s = {RETRY_W{1'b0}};
                end else begin
                    state_s = ST_POST_RST;
                end
            end
            ST_INIT: begin
                // A done seen on the timeout cycle still counts as success
                if (done_s) begin
                    state_s = ST_NEXT;
                end else if (at_term_s) begin
                    if (retry_r < RETRY_MAX) begin
                        state_s = ST_RETRY;
                        retry_s = retry_r + 3'd1;
                    end else begin
                        state_s       = ST_NEXT;
                        err_s[idx_r]  = 1'b1;
                    end
                end else begin
                    state_s = ST_INIT;
                end
            end
            ST_RETRY: begin
                state_s = ST_INIT;
            end
            ST_NEXT: begin
                if (idx_r == IDX_LAST) begin
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_INIT;
                    idx_s   = idx_r + IDX_W'(1'b1);
                    retry_s = {RETRY_W{1'b0}};
                end
            end
            ST_SETTLE: begin
                if (at_term_s) state_s = ST_RUN;
                else           state_s = ST_SETTLE;
            end
            ST_RUN: begin
                if (REINIT) begin
                    state_s = ST_PRE_RST;
                    err_s   = {N_ADC{1'b0}};
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // One-hot init strobe for the chip the next state will be talking to
    always_comb begin
        init_vec_s = {N_ADC{1'b0}};
        for (int i = 0; i < N_ADC; i++) begin
            init_vec_s[i] = (state_s == ST_INIT) && (idx_s == IDX_W'(i));
        end
    end

    // State, bookkeeping and output registers, all decoded from the next state
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r    <= ST_IDLE;
            idx_r      <= {IDX_W{1'b0}};
            retry_r    <= {RETRY_W{1'b0}};
            err_r      <= {N_ADC{1'b0}};
            adc_rst_r  <= 1'b0;
            adc_init_r <= {N_ADC{1'b0}};
            busy_r     <= 1'b1;
            run_r      <= 1'b0;
            all_ok_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            retry_r    <= retry_s;
            err_r      <= err_s;
            adc_rst_r  <= (state_s == ST_ADC_RSTP);
            adc_init_r <= init_vec_s;
            busy_r     <= (state_s != ST_RUN);
            run_r      <= (state_s == ST_RUN);
            all_ok_r   <= (state_s == ST_RUN) && ~|err_s;
        end
    end

    assign ADC_RST  = adc_rst_r;
    assign ADC_INIT = adc_init_r;
    assign BUSY     = busy_r;
    assign RUN      = run_r;
    assign ALL_OK   = all_ok_r;
    assign ERR      = err_r;

endmodule

// File: tb/tb_adc_init_seq.sv
// Scoreboard bench for adc_init_seq: expected output changes are planned from the
// sequence timing and compared against every observed change of the output bundle.
module tb_adc_init_seq;

    localparam int N  = 6;
    localparam int SD = 5;
    localparam int RL = 7;
    localparam int ID = 5;
    localparam int TO = 4000;
    localparam int MR = 2;
    localparam int ST = 1000;
    localparam int BW = 2 * N + 4;

    typedef struct {
        int            cyc;
        logic [BW-1:0] val;
    } exp_t;

    logic          CLK;
    logic          RST_N;
    logic          REINIT;
    logic [N-1:0]  INIT_DONE;
    logic          ADC_RST;
    logic [N-1:0]  ADC_INIT;
    logic          BUSY;
    logic          RUN;
    logic          ALL_OK;
    logic [N-1:0]  ERR;

    logic          RST1_N;
    logic          REINIT1;
    logic [0:0]    INIT_DONE1;
    logic          ADC_RST1;
    logic [0:0]    ADC_INIT1;
    logic          BUSY1;
    logic          RUN1;
    logic          ALL_OK1;
    logic [0:0]    ERR1;

    logic [BW-1:0] obs_bus;
    logic [BW-1:0] last_exp;
    logic [BW-1:0] prev_obs;
    logic          e_rst;
    logic          e_busy;
    logic          e_run;
    logic          e_ok;
    logic [N-1:0]  e_init;
    logic [N-1:0]  e_err;
    int            cyc;
    int            n_vec;
    int            n_bad;
    int            resp [N];
    bit            mon_en;
    exp_t          sb [$];

    assign obs_bus = {ADC_RST, ADC_INIT, BUSY, RUN, ALL_OK, ERR};

    adc_init_seq dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .REINIT    (REINIT),
        .INIT_DONE (INIT_DONE),
        .ADC_RST   (ADC_RST),
        .ADC_INIT  (ADC_INIT),
        .BUSY      (BUSY),
        .RUN       (RUN),
        .ALL_OK    (ALL_OK),
        .ERR       (ERR)
    );

    adc_init_seq #(
        .N_ADC     (1),
        .TIMEOUT   (10),
        .MAX_RETRY (0),
        .SETTLE    (20)
    ) dut1 (
        .CLK       (CLK),
        .RST_N     (RST1_N),
        .REINIT    (REINIT1),
        .INIT_DONE (INIT_DONE1),
        .ADC_RST   (ADC_RST1),
        .ADC_INIT  (ADC_INIT1),
        .BUSY      (BUSY1),
        .RUN       (RUN1),
        .ALL_OK    (ALL_OK1),
        .ERR       (ERR1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge CLK);
            cyc = cyc + 1;
        end
    end

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec = n_vec + 1;
        if (obs !== exp_v) begin
            n_bad = n_bad + 1;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic push_at(input int c);
        logic [BW-1:0] v;
        v = {e_rst, e_init, e_busy, e_run, e_ok, e_err};
        if (v !== last_exp) begin
            sb.push_back('{c, v});
            last_exp = v;
        end
    endtask

    // wake #2 after the first edge whose number is >= c
    task automatic at_cycle(input int c);
        do begin
            @(posedge CLK);
            #2;
        end while (cyc < c);
    endtask

    // plan a full sequence whose PRE_RST is entered on edge s
    task automatic plan_seq(input int s, output int run_c);
        int e;
        int f;
        e = s + SD;
        e_rst = 1'b1;
        push_at(e);
        e = e + RL;
        e_rst = 1'b0;
        push_at(e);
        e = e + ID;
        f = e;
        for (int i = 0; i < N; i++) begin
            if (resp[i] != 0 && resp[i] <= TO) begin
                e_init = '0;
                e_init[i] = 1'b1;
                push_at(e);
                e_init = '0;
                f = e + resp[i];
                push_at(f);
                e = f + 1;
            end else begin
                for (int a = 0; a <= MR; a++) begin
                    e_init = '0;
                    e_init[i] = 1'b1;
                    push_at(e);
                    e_init = '0;
                    if (a == MR) e_err[i] = 1'b1;
                    f = e + TO;
                    push_at(f);
                    e = f + 1;
                end
            end
        end
        run_c  = f + 1 + ST;
        e_busy = 1'b0;
        e_run  = 1'b1;
        e_ok   = (e_err == '0);
        push_at(run_c);
    endtask

    // config-engine model: chip i raises INIT_DONE resp[i] cycles into its window
    initial begin
        int cnt [N];
        INIT_DONE = '0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        forever begin
            @(negedge CLK);
            for (int i = 0; i < N; i++) begin
                if (ADC_INIT[i]) cnt[i] = cnt[i] + 1;
                else             cnt[i] = 0;
                INIT_DONE[i] = (resp[i] != 0) && (cnt[i] >= resp[i]);
            end
        end
    end

    // scoreboard: every change of the output bundle must match the next planned change
    initial begin
        exp_t sb_e;
        forever begin
            @(negedge CLK);
            if (mon_en && (obs_bus !== prev_obs)) begin
                if (sb.size() == 0) begin
                    chk_val("spurious_change", obs_bus, prev_obs);
                end else begin
                    sb_e = sb.pop_front();
                    chk_val("change_cycle", cyc, sb_e.cyc);
                    chk_val("change_value", obs_bus, sb_e.val);
                end
                prev_obs = obs_bus;
            end
        end
    end

    initial begin
        int s;
        int e0;
        int run_c;
        int g;
        int k;
        n_vec      = 0;
        n_bad      = 0;
        mon_en     = 1'b0;
        RST_N      = 1'b0;
        RST1_N     = 1'b0;
        REINIT     = 1'b0;
        REINIT1    = 1'b0;
        INIT_DONE1 = 1'b0;
        for (int i = 0; i < N; i++) resp[i] = 3;
        e_rst  = 1'b0;
        e_init = '0;
        e_busy = 1'b1;
        e_run  = 1'b0;
        e_ok   = 1'b0;
        e_err  = '0;
        last_exp = {e_rst, e_init, e_busy, e_run, e_ok, e_err};

        at_cycle(2);
        chk_val("reset_bundle", obs_bus, last_exp);
        chk_val("reset_bundle_n1", {ADC_RST1, ADC_INIT1, BUSY1, RUN1, ALL_OK1, ERR1}, 6'b001000);
        prev_obs = obs_bus;
        mon_en   = 1'b1;

        // sequence A: all chips answer after 3 cycles, REINIT during INIT ignored
        at_cycle(3);
        s  = 4;
        e0 = s + SD + RL + ID;
        plan_seq(s, run_c);
        RST_N  = 1'b1;
        RST1_N = 1'b1;
        fork
            begin
                at_cycle(s + 5);  chk_val("n1_rst_rise", ADC_RST1, 1'b1);
                at_cycle(s + 11); chk_val("n1_rst_hold", ADC_RST1, 1'b1);
                at_cycle(s + 12); chk_val("n1_rst_fall", ADC_RST1, 1'b0);
                at_cycle(s + 16); chk_val("n1_init_pre", ADC_INIT1, 1'b0);
                at_cycle(s + 17); chk_val("n1_init_on", ADC_INIT1, 1'b1);
                at_cycle(s + 26); chk_val("n1_init_last", ADC_INIT1, 1'b1);
                at_cycle(s + 27); chk_val("n1_init_off", ADC_INIT1, 1'b0);
                                  chk_val("n1_err", ERR1, 1'b1);
                at_cycle(s + 47); chk_val("n1_run_pre", RUN1, 1'b0);
                at_cycle(s + 48); chk_val("n1_run", RUN1, 1'b1);
                                  chk_val("n1_all_ok", ALL_OK1, 1'b0);
                                  chk_val("n1_busy", BUSY1, 1'b0);
            end
            begin
                at_cycle(e0 + 12);
                REINIT = 1'b1;
                at_cycle(e0 + 13);
                REINIT = 1'b0;
            end
        join
        at_cycle(run_c + 2);
        chk_val("seqA_pending", sb.size(), 0);
        chk_val("seqA_err", ERR, 6'b000000);
        chk_val("seqA_all_ok", ALL_OK, 1'b1);

        // sequence B: REINIT in RUN, chip 1 answers on its last cycle, chip 2 silent
        resp[1] = TO;
        resp[2] = 0;
        g = run_c + 6;
        e_busy = 1'b1;
        e_run  = 1'b0;
        e_ok   = 1'b0;
        e_err  = '0;
        push_at(g);
        plan_seq(g, run_c);
        at_cycle(g - 1);
        REINIT = 1'b1;
        at_cycle(g);
        REINIT = 1'b0;
        chk_val("seqB_busy", BUSY, 1'b1);
        at_cycle(run_c + 2);
        chk_val("seqB_pending", sb.size(), 0);
        chk_val("seqB_err", ERR, 6'b000100);
        chk_val("seqB_run", RUN, 1'b1);
        chk_val("seqB_all_ok", ALL_OK, 1'b0);

        // sequence C: REINIT clears ERR, then reset lands inside the ADC reset pulse
        for (int i = 0; i < N; i++) resp[i] = 3;
        g = run_c + 6;
        e_busy = 1'b1;
        e_run  = 1'b0;
        e_ok   = 1'b0;
        e_err  = '0;
        push_at(g);
        plan_seq(g, run_c);
        at_cycle(g - 1);
        REINIT = 1'b1;
        at_cycle(g);
        REINIT = 1'b0;
        chk_val("reinit_err_clr", ERR, 6'b000000);
        chk_val("reinit_busy", BUSY, 1'b1);
        k = g + SD + 3;
        at_cycle(k);
        chk_val("abort_rst_high", ADC_RST, 1'b1);
        RST_N = 1'b0;
        #1;
        chk_val("abort_rst_async", ADC_RST, 1'b0);
        chk_val("abort_busy", BUSY, 1'b1);
        sb.delete();
        e_rst  = 1'b0;
        e_init = '0;
        e_busy = 1'b1;
        e_run  = 1'b0;
        e_ok   = 1'b0;
        e_err  = '0;
        push_at(k);
        at_cycle(k + 3);
        RST_N = 1'b1;
        plan_seq(k + 4, run_c);
        at_cycle(run_c + 2);
        chk_val("seqD_pending", sb.size(), 0);
        chk_val("seqD_all_ok", ALL_OK, 1'b1);
        chk_val("seqD_err", ERR, 6'b000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
